// File: rtl/vram_rect_writer.sv
// vram_rect_writer: fills a clipped rectangle of the 400x240 RGB565 frame
// buffer with one colour, issuing one word write per clock in row-major order.
module vram_rect_writer #(
    parameter int H_RES  = 400,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              iACLK,
    input  logic              iRST,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic [8:0]        iX,
    input  logic [7:0]        iY,
    input  logic [8:0]        iW,
    input  logic [7:0]        iH,
    input  logic [15:0]       iCOLOR,
    input  logic              iHOLD,
    output logic [ADDR_W-1:0] oADDR,
    output logic [15:0]       oWDATA,
    output logic              oWRITE,
    output logic [1:0]        oBYTEEN,
    output logic              oBUSY,
    output logic              oDONE
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

    state_t            state;

    // Latched command
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [15:0]       cmd_color;

    // Fill walk: col/row/row_base always name the next pixel to issue
    logic [8:0]        w_eff;
    logic [7:0]        h_eff;
    logic [8:0]        col;
    logic [7:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic              last_sent;

    // Clip results derived from the latched command during SETUP
    logic [9:0]        x_room;
    logic [8:0]        y_room;
    logic [8:0]        w_clip;
    logic [7:0]        h_clip;
    logic              empty;
    logic [ADDR_W-1:0] base0;
    logic              at_row_end;
    logic              at_last;
    logic              take_cmd;
    logic              advance;

    // y*H_RES + x; shift-add for the native 400-pixel stride, no multiplier
    function automatic logic [ADDR_W-1:0] row_start(input logic [7:0] y, input logic [8:0] x);
        logic [ADDR_W-1:0] ye;
        logic [ADDR_W-1:0] xe;
        ye = ADDR_W'(y);
        xe = ADDR_W'(x);
        if (H_RES == 400)
            return (ye << 8) + (ye << 7) + (ye << 4) + xe;
        else
            return ADDR_W'(ye * ADDR_W'(H_RES)) + xe;
    endfunction

    assign oBYTEEN = 2'b11;

    // Clip the rectangle against the screen edges and find the first address
    always_comb begin
        x_room = 10'(H_RES) - {1'b0, cmd_x};
        y_room = 9'(V_RES) - {1'b0, cmd_y};
        w_clip = ({1'b0, cmd_w} < x_room) ? cmd_w : x_room[8:0];
        h_clip = ({1'b0, cmd_h} < y_room) ? cmd_h : y_room[7:0];
        empty  = ({1'b0, cmd_x} >= 10'(H_RES)) || ({1'b0, cmd_y} >= 9'(V_RES)) ||
                 (cmd_w == 9'd0) || (cmd_h == 8'd0);
        base0  = row_start(cmd_y, cmd_x);
    end

    assign at_row_end = (col == w_eff - 9'd1);
    assign at_last    = at_row_end && (row == h_eff - 8'd1);
    assign take_cmd   = (state == S_IDLE) && iCMD_VALID && oCMD_READY;
    assign advance    = (state == S_FILL) && !iHOLD && !last_sent;

    // Datapath: command capture and pixel walk (no reset needed)
    always_ff @(posedge iACLK) begin
        if (take_cmd) begin
            cmd_x     <= iX;
            cmd_y     <= iY;
            cmd_w     <= iW;
            cmd_h     <= iH;
            cmd_color <= iCOLOR;
        end else if (state == S_SETUP) begin
            w_eff <= w_clip;
            h_eff <= h_clip;
            // pixel (0,0) is issued in SETUP, so step to the one after it
            if (w_clip == 9'd1) begin
                col      <= 9'd0;
                row      <= 8'd1;
                row_base <= base0 + ADDR_W'(H_RES);
            end else begin
                col      <= 9'd1;
                row      <= 8'd0;
                row_base <= base0;
            end
        end else if (advance) begin
            if (at_row_end) begin
                col      <= 9'd0;
                row      <= row + 8'd1;
                row_base <= row_base + ADDR_W'(H_RES);
            end else begin
                col <= col + 9'd1;
            end
        end
    end

    // Control FSM with registered handshake and write-port outputs
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state      <= S_IDLE;
            oCMD_READY <= 1'b1;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oWRITE     <= 1'b0;
            oADDR      <= '0;
            oWDATA     <= '0;
            last_sent  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    oDONE  <= 1'b0;
                    oWRITE <= 1'b0;
                    if (take_cmd) begin
                        state      <= S_SETUP;
                        oCMD_READY <= 1'b0;
                        oBUSY      <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (empty) begin
                        state <= S_DONE;
                        oDONE <= 1'b1;
                    end else begin
                        state     <= S_FILL;
                        oWRITE    <= 1'b1;
                        oADDR     <= base0;
                        oWDATA    <= cmd_color;
                        last_sent <= (w_clip == 9'd1) && (h_clip == 8'd1);
                    end
                end
                S_FILL: begin
                    if (last_sent) begin
                        state     <= S_DONE;
                        oWRITE    <= 1'b0;
                        oDONE     <= 1'b1;
                        last_sent <= 1'b0;
                    end else if (iHOLD) begin
                        oWRITE <= 1'b0;
                    end else begin
                        oWRITE    <= 1'b1;
                        oADDR     <= row_base + ADDR_W'(col);
                        last_sent <= at_last;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    oDONE      <= 1'b0;
                    oBUSY      <= 1'b0;
                    oCMD_READY <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_rect_writer.sv
// Testbench for vram_rect_writer: directed and random fills compared against
// a per-pixel reference built from the screen geometry.
module tb_vram_rect_writer;

    localparam int ADDR_W = 17;

    logic              iACLK = 1'b0;
    logic              iRST;
    logic              iCMD_VALID;
    logic              oCMD_READY;
    logic [8:0]        iX;
    logic [7:0]        iY;
    logic [8:0]        iW;
    logic [7:0]        iH;
    logic [15:0]       iCOLOR;
    logic              iHOLD;
    logic [ADDR_W-1:0] oADDR;
    logic [15:0]       oWDATA;
    logic              oWRITE;
    logic [1:0]        oBYTEEN;
    logic              oBUSY;
    logic              oDONE;

    int errors = 0;
    int checks = 0;

    vram_rect_writer #(.H_RES(400), .V_RES(240), .ADDR_W(ADDR_W)) dut (
        .iACLK(iACLK), .iRST(iRST), .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY),
        .iX(iX), .iY(iY), .iW(iW), .iH(iH), .iCOLOR(iCOLOR), .iHOLD(iHOLD),
        .oADDR(oADDR), .oWDATA(oWDATA), .oWRITE(oWRITE), .oBYTEEN(oBYTEEN),
        .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 iACLK = ~iACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command (caller is at a negedge) and check the whole response.
    // Hold is raised in the cycle where write number hs (1-based) is visible,
    // for hl cycles; hs=0 means no hold.
    task automatic do_cmd(input string name, input int x, input int y, input int w, input int h,
                          input logic [15:0] c, input int hs, input int hl);
        int we, he, n, s, exp_done, cyc, done_cnt, m;
        int ea[$];
        int ec[$];
        int ga[$];
        int gd[$];
        int gc[$];
        // reference: clipped rectangle, row-major, stride 400
        we = 0;
        he = 0;
        if (x < 400 && y < 240) begin
            we = (w < 400 - x) ? w : 400 - x;
            he = (h < 240 - y) ? h : 240 - y;
        end
        n = we * he;
        s = (hs >= 1 && hs < n) ? hl : 0;
        for (int r = 0; r < he; r++)
            for (int cc = 0; cc < we; cc++) begin
                int i;
                i = r * we + cc;
                ea.push_back((y + r) * 400 + x + cc);
                ec.push_back(2 + i + ((s > 0 && i >= hs) ? s : 0));
            end
        exp_done = 2 + n + s;

        chk({name, " ready_before"}, 32'(oCMD_READY), 32'd1);
        iCMD_VALID = 1'b1;
        iX = 9'(x);
        iY = 8'(y);
        iW = 9'(w);
        iH = 8'(h);
        iCOLOR = c;
        @(posedge iACLK);
        cyc = 0;
        done_cnt = 0;
        while (cyc < exp_done + 1) begin
            @(negedge iACLK);
            cyc++;
            if (cyc == 1) begin
                iCMD_VALID = 1'b0;
                iX = 9'($urandom);
                iY = 8'($urandom);
                iW = 9'($urandom);
                iH = 8'($urandom);
                iCOLOR = 16'($urandom);
            end
            iHOLD = (s > 0 && cyc >= 1 + hs && cyc <= hs + hl);
            if (oWRITE === 1'b1) begin
                ga.push_back(int'(oADDR));
                gd.push_back(int'(oWDATA));
                gc.push_back(cyc);
            end
            if (oDONE === 1'b1) begin
                done_cnt++;
                chk({name, " done_cycle"}, 32'(cyc), 32'(exp_done));
            end
            if (cyc == 1 || cyc == exp_done || cyc == exp_done + 1) begin
                chk({name, " busy"}, 32'(oBUSY), 32'(cyc <= exp_done));
                chk({name, " ready"}, 32'(oCMD_READY), 32'(cyc > exp_done));
            end
        end
        iHOLD = 1'b0;
        chk({name, " done_count"}, 32'(done_cnt), 32'd1);
        chk({name, " write_count"}, 32'(ga.size()), 32'(n));
        m = (ga.size() < n) ? ga.size() : n;
        for (int i = 0; i < m; i++) begin
            chk({name, " addr"}, 32'(ga[i]), 32'(ea[i]));
            chk({name, " data"}, 32'(gd[i]), 32'(c));
            chk({name, " write_cycle"}, 32'(gc[i]), 32'(ec[i]));
        end
    endtask

    initial begin
        int wr;
        int budget;
        iRST = 1'b1;
        iCMD_VALID = 1'b0;
        iX = '0;
        iY = '0;
        iW = '0;
        iH = '0;
        iCOLOR = '0;
        iHOLD = 1'b0;
        repeat (3) @(posedge iACLK);
        @(negedge iACLK);
        iRST = 1'b0;

        // reset state
        chk("rst_ready", 32'(oCMD_READY), 32'd1);
        chk("rst_write", 32'(oWRITE), 32'd0);
        chk("rst_addr", 32'(oADDR), 32'd0);
        chk("rst_wdata", 32'(oWDATA), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_byteen", 32'(oBYTEEN), 32'd3);

        // directed fills
        do_cmd("fill2x2", 0, 0, 2, 2, 16'hF800, 0, 0);
        do_cmd("clip", 398, 239, 5, 3, 16'h1234, 0, 0);
        do_cmd("empty_w0", 5, 5, 0, 4, 16'hAAAA, 0, 0);
        do_cmd("empty_x400", 400, 0, 3, 3, 16'h5555, 0, 0);
        do_cmd("empty_y240", 0, 240, 3, 3, 16'h5555, 0, 0);
        do_cmd("hold4x1", 10, 5, 4, 1, 16'h001F, 2, 3);
        do_cmd("col1", 7, 100, 1, 4, 16'hBEEF, 0, 0);
        do_cmd("wide_rows", 0, 0, 400, 20, 16'h07E0, 0, 0);
        do_cmd("bottom_full", 0, 230, 400, 240, 16'h07E0, 0, 0);

        // random fills, some with a hold burst
        for (int k = 0; k < 10; k++) begin
            int rx, ry, rw, rh, hs, hl;
            rx = $urandom_range(0, 420);
            ry = $urandom_range(0, 250);
            rw = $urandom_range(0, 40);
            rh = $urandom_range(0, 20);
            hs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            hl = $urandom_range(1, 5);
            do_cmd("random", rx, ry, rw, rh, 16'($urandom), hs, hl);
        end

        // reset in the middle of a 10x10 fill
        chk("mid_ready", 32'(oCMD_READY), 32'd1);
        iCMD_VALID = 1'b1;
        iX = 9'd0;
        iY = 8'd0;
        iW = 9'd10;
        iH = 8'd10;
        iCOLOR = 16'hFFFF;
        @(posedge iACLK);
        @(negedge iACLK);
        iCMD_VALID = 1'b0;
        wr = 0;
        budget = 0;
        while (wr < 15 && budget < 40) begin
            if (oWRITE === 1'b1) wr++;
            if (wr < 15) begin
                @(negedge iACLK);
                budget++;
            end
        end
        chk("mid_writes_reached", 32'(wr), 32'd15);
        iRST = 1'b1;
        @(negedge iACLK);
        iRST = 1'b0;
        chk("mid_write_low", 32'(oWRITE), 32'd0);
        chk("mid_ready_high", 32'(oCMD_READY), 32'd1);
        chk("mid_busy_low", 32'(oBUSY), 32'd0);
        chk("mid_done_low", 32'(oDONE), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iACLK);
            chk("mid_idle_done", 32'(oDONE), 32'd0);
            chk("mid_idle_write", 32'(oWRITE), 32'd0);
        end
        do_cmd("after_reset1x1", 0, 0, 1, 1, 16'h8421, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
